// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multicycle MIPS-subset CPU (datapath + control FSM).
// Connects to one unified memory through a req/ready handshake, so the memory may add wait states.
// It halts on an illegal opcode, on a misaligned fetch and on a misaligned lw/sw.
// It also counts retired instructions and non-halted cycles.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   mem_req      memory access request
//   mem_we       1 = write, 0 = read (valid with mem_req)
//   mem_adr      byte address (valid with mem_req)
//   mem_wdata    store data, i.e. rt value (valid with mem_req & mem_we)
//   mem_rdata    read data, sampled when mem_ready=1
//   mem_ready    access completes in a cycle where mem_req=1 and mem_ready=1
//   pc           current PC register
//   halted       core is in the absorbing HALT state
//   cycle_cnt    clocks since reset, excluding HALT cycles
//   instret_cnt  instructions retired
module mc_cpu_core #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter bit          ENABLE_BNE = 1'b1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_adr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [31:0]      pc,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExec, StWb, StMaddr, StMrd, StMwb, StMwr, StBr, StJmp, StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       aluout_q, aluout_d;
    logic [31:0]       mdr_q, mdr_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [31:0]       regs_q [32];
    logic [31:0]       regs_d [32];

    // Instruction fields
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext;
    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign func     = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        retire;
    logic [31:0] alu_b;
    logic [31:0] maddr;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        aluout_d  = aluout_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'h0;
        retire    = 1'b0;
        alu_b     = (op == OpRtype) ? b_q : imm_sext;
        maddr     = a_q + imm_sext;

        unique case (state_q)
            StFetch: begin
                if (pc_q[1:0] != 2'b00) begin
                    state_d = StHalt;
                end else if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d      = regs_q[rs];
                b_d      = regs_q[rt];
                // Branch target precomputed from the already-incremented PC
                aluout_d = pc_q + (imm_sext << 2);
                case (op)
                    OpRtype: begin
                        if (func == FnJr) begin
                            state_d = StJmp;
                        end else if (func == FnAdd || func == FnSub || func == FnAnd ||
                                     func == FnOr || func == FnSlt) begin
                            state_d = StExec;
                        end else begin
                            state_d = StHalt;
                        end
                    end
                    OpAddi, OpSlti: state_d = StExec;
                    OpLw, OpSw:     state_d = StMaddr;
                    OpBeq:          state_d = StBr;
                    OpBne:          state_d = ENABLE_BNE ? StBr : StHalt;
                    OpJ, OpJal:     state_d = StJmp;
                    default:        state_d = StHalt;
                endcase
            end
            StExec: begin
                if (op == OpRtype) begin
                    case (func)
                        FnSub:   aluout_d = a_q - alu_b;
                        FnAnd:   aluout_d = a_q & alu_b;
                        FnOr:    aluout_d = a_q | alu_b;
                        FnSlt:   aluout_d = {31'h0, $signed(a_q) < $signed(alu_b)};
                        default: aluout_d = a_q + alu_b;
                    endcase
                end else if (op == OpSlti) begin
                    aluout_d = {31'h0, $signed(a_q) < $signed(alu_b)};
                end else begin
                    aluout_d = a_q + alu_b;
                end
                state_d = StWb;
            end
            StWb: begin
                rf_we    = 1'b1;
                rf_waddr = (op == OpRtype) ? rd : rt;
                rf_wdata = aluout_q;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StMaddr: begin
                aluout_d = maddr;
                if (maddr[1:0] != 2'b00) begin
                    state_d = StHalt;
                end else begin
                    state_d = (op == OpLw) ? StMrd : StMwr;
                end
            end
            StMrd: begin
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = StMwb;
                end
            end
            StMwb: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = mdr_q;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StMwr: begin
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StBr: begin
                if ((op == OpBeq) ? (a_q == b_q) : (a_q != b_q)) begin
                    pc_d = aluout_q;
                end
                retire  = 1'b1;
                state_d = StFetch;
            end
            StJmp: begin
                if (op == OpRtype) begin
                    pc_d = a_q;
                end else begin
                    pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                    if (op == OpJal) begin
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc_q;
                    end
                end
                retire  = 1'b1;
                state_d = StFetch;
            end
            default: begin
                // HALT absorbs everything until reset
                state_d = StHalt;
            end
        endcase

        regs_d = regs_q;
        if (rf_we && rf_waddr != 5'd0) begin
            regs_d[rf_waddr] = rf_wdata;
        end

        cycle_d   = (state_q != StHalt) ? cycle_q + CNT_W'(1) : cycle_q;
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            aluout_q  <= 32'h0;
            mdr_q     <= 32'h0;
            cycle_q   <= '0;
            instret_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            aluout_q  <= aluout_d;
            mdr_q     <= mdr_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            regs_q    <= regs_d;
        end
    end

    // Request is decoded from the state so the first fetch after reset needs no extra cycle;
    // gating with rst keeps it low while reset is held.
    assign mem_req     = rst && ((state_q == StFetch && pc_q[1:0] == 2'b00) ||
                                 state_q == StMrd || state_q == StMwr);
    assign mem_we      = (state_q == StMwr);
    assign mem_adr     = (state_q == StFetch) ? pc_q : aluout_q;
    assign mem_wdata   = b_q;
    assign pc          = pc_q;
    assign halted      = (state_q == StHalt);
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule
